// File: rtl/ysyx_22041211_ifu.sv
// ============================================================================
// ysyx_22041211_ifu : multi-cycle instruction fetch over an AXI4-Lite read port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ysyx_22041211_ifu #(
  parameter int unsigned          ADDR_LEN = 32,
  parameter int unsigned          DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0]  RESET_PC = ADDR_LEN'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic                inst_err_o,
  input  logic                redirect_i,
  input  logic [ADDR_LEN-1:0] redirect_pc_i,
  input  logic                flush_i,
  input  logic [ADDR_LEN-1:0] flush_pc_i
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [ADDR_LEN-1:0] araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                inst_valid_q, inst_valid_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic                inst_err_q, inst_err_d;
  logic                drop_q, drop_d;

  // Shared "start a new fetch at enter_pc" path used by every transition into REQ.
  logic                enter_req;
  logic [ADDR_LEN-1:0] enter_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_err_d   = inst_err_q;
    drop_d       = drop_q;
    enter_req    = 1'b0;
    enter_pc     = pc_q;

    case (state_q)
      REQ: begin
        if (!arvalid_q) begin
          // No request on the bus yet: either start one or report misalignment.
          if (flush_i) begin
            enter_req = 1'b1;
            enter_pc  = flush_pc_i;
          end else if (pc_q[1:0] != 2'b00) begin
            state_d      = HOLD;
            inst_valid_d = 1'b1;
            inst_d       = '0;
            inst_err_d   = 1'b1;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = pc_q;
          end
        end else begin
          if (arready_i) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RESP;
          end
          // The address phase cannot be withdrawn, so its response is marked for discard.
          if (flush_i) begin
            pc_d   = flush_pc_i;
            drop_d = 1'b1;
          end
        end
      end

      RESP: begin
        if (rvalid_i) begin
          if (flush_i) begin
            drop_d    = 1'b0;
            enter_req = 1'b1;
            enter_pc  = flush_pc_i;
          end else if (drop_q) begin
            drop_d    = 1'b0;
            enter_req = 1'b1;
            enter_pc  = pc_q;
          end else begin
            rready_d     = 1'b0;
            inst_d       = rdata_i;
            inst_err_d   = (rresp_i != 2'b00);
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (flush_i) begin
          pc_d   = flush_pc_i;
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (flush_i) begin
          enter_req = 1'b1;
          enter_pc  = flush_pc_i;
        end else if (inst_ready_i) begin
          enter_req = 1'b1;
          enter_pc  = redirect_i ? redirect_pc_i : pc_q + ADDR_LEN'(4);
        end
      end

      default: begin
        enter_req = 1'b1;
        enter_pc  = pc_q;
      end
    endcase

    // Aligned targets go straight onto the bus; misaligned ones are caught in REQ.
    if (enter_req) begin
      state_d      = REQ;
      pc_d         = enter_pc;
      araddr_d     = enter_pc;
      arvalid_d    = (enter_pc[1:0] == 2'b00);
      rready_d     = 1'b0;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      araddr_q     <= RESET_PC;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_err_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_err_q   <= inst_err_d;
      drop_q       <= drop_d;
    end
  end

  assign araddr_o     = araddr_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_err_o   = inst_err_q;

endmodule

`default_nettype wire
